// File: rtl/md_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl_pkg
// Description : Shared definitions for the multiply/divide controller.
//               Holds the op encodings, the FSM state encoding, the divide
//               iteration count and a magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package md_ctrl_pkg;

    // Operation encodings as presented on the op port
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Number of restoring steps for a 32-bit divide
    localparam int DIV_ITER = 32;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } md_state_t;

    // Magnitude of a 32-bit value; only negates when the value is to be
    // interpreted as signed and is negative.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_ctrl_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration.
//               i_rq holds {partial remainder, dividend/quotient bits}.
//               The pair is shifted left by one; if the shifted remainder is
//               at least the divisor, the divisor is subtracted and a 1 is
//               shifted into the quotient, otherwise a 0.
// Ports       : i_rq      [63:0]  current remainder/quotient pair
//               i_divisor [31:0]  divisor magnitude (non-zero)
//               o_rq      [63:0]  next remainder/quotient pair
// Revision    : 1.0 - initial release
// ============================================================================
module div_step (
    input  logic [63:0] i_rq,
    input  logic [31:0] i_divisor,
    output logic [63:0] o_rq
);

    logic        w_ge;
    logic [31:0] w_diff;

    // The shifted remainder is 33 bits (i_rq[63:31]). If its top bit is set
    // it certainly exceeds the divisor; the 32-bit modular difference is then
    // still exact because the true difference is below 2^32.
    assign w_ge   = i_rq[63] | (i_rq[62:31] >= i_divisor);
    assign w_diff = i_rq[62:31] - i_divisor;

    assign o_rq = w_ge ? {w_diff, i_rq[30:0], 1'b1}
                       : {i_rq[62:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
//               Multiplies complete in one stall cycle; divides run a
//               32-step restoring algorithm on magnitudes with the sign
//               fixed up when the result is registered.
// Ports       : clk, resetn          clock, async active-low reset
//               start, op[1:0]       request and operation
//               src_a, src_b [31:0]  rs / rt operands
//               flush, hold          pipeline cancel / freeze
//               stall_o              freeze IF/ID/EX
//               valid_o              hi_o/lo_o hold the final result
//               hi_o, lo_o [31:0]    HI / LO result
//               busy_o               controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hold,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    localparam logic [5:0] c_last_step = 6'(DIV_ITER - 1);

    md_state_t   r_state;
    md_state_t   w_next_state;
    logic [1:0]  r_op;
    logic [31:0] r_src_a;
    logic [31:0] r_src_b;
    logic [5:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_r_signed;
    logic [31:0] w_divisor;
    logic [63:0] w_step_in;
    logic [63:0] w_step_out;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept = (r_state == IDLE) && start && !flush;

    // Operands sign/zero extended to 64 bits; the low 64 bits of the
    // product are then the exact signed/unsigned result.
    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Divide datapath works on magnitudes of the latched operands. The
    // dividend is loaded into the accumulator on the first step.
    assign w_r_signed = (r_op == MD_DIV);
    assign w_divisor  = md_abs(r_src_b, w_r_signed);
    assign w_step_in  = (r_count == 6'd0) ? {32'd0, md_abs(r_src_a, w_r_signed)} : r_acc;

    div_step u_div_step (
        .i_rq      (w_step_in),
        .i_divisor (w_divisor),
        .o_rq      (w_step_out)
    );

    assign w_quot = (w_r_signed && (r_src_a[31] ^ r_src_b[31])) ? (32'd0 - w_step_out[31:0])
                                                                : w_step_out[31:0];
    assign w_rem  = (w_r_signed && r_src_a[31]) ? (32'd0 - w_step_out[63:32])
                                                : w_step_out[63:32];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (op[1] && (src_b != 32'd0)) begin
                            w_next_state = DIV_RUN;
                        end else begin
                            w_next_state = DONE;
                        end
                    end
                end
                DIV_RUN: begin
                    if (r_count == c_last_step) begin
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op    <= 2'd0;
            r_src_a <= 32'd0;
            r_src_b <= 32'd0;
            r_count <= 6'd0;
            r_acc   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_accept) begin
            r_op    <= op;
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_count <= 6'd0;
            if (!op[1]) begin
                {r_hi, r_lo} <= (op == MD_MULT) ? w_prod_s : w_prod_u;
            end else if (src_b == 32'd0) begin
                r_hi <= src_a;
                r_lo <= 32'hFFFF_FFFF;
            end
        end else if ((r_state == DIV_RUN) && !flush) begin
            r_acc   <= w_step_out;
            r_count <= r_count + 6'd1;
            if (r_count == c_last_step) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end
        end
    end

    // Stall is also forced low while reset is held, so a start presented
    // during reset cannot freeze the pipeline.
    assign stall_o = resetn && !flush &&
                     (((r_state == IDLE) && start) || (r_state == DIV_RUN));
    assign valid_o = (r_state == DONE) && !flush;
    assign busy_o  = (r_state != IDLE);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule
`default_nettype wire
